uart_rx_param: RTL



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_param.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive types, parameter legality check and parity helper.
// Pure declarations: no latency, no flow control.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } uart_rx_state_t;

   function automatic bit uart_rx_params_ok(input int data_bits, input int oversample,
                                            input int parity_en, input int parity_odd,
                                            input int stop_bits);
      return (data_bits >= 5) && (data_bits <= 9) &&
             (oversample >= 8) && (oversample <= 32) && (oversample % 2 == 0) &&
             (parity_en inside {0, 1}) && (parity_odd inside {0, 1}) &&
             (stop_bits inside {1, 2});
   endfunction

   // High when the data word plus the received parity bit break the selected rule.
   // Unused upper data bits must be zero, which leaves the reduction unchanged.
   function automatic logic parity_bad(input logic [8:0] data, input logic par_bit,
                                       input logic odd);
      return ^data ^ par_bit ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high line; 2 clk latency, no flow control.
// Both stages reset high so the line reads as idle straight out of reset.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver; frame lands in dout (frame bits - 0.5) bit periods + 4 clk after the start edge.
// Never stalls: a frame finishing while dout is unread and not being taken is dropped with an overrun_err pulse.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 smpl_tick
);

   if (!uart_rx_params_ok(DATA_BITS, OVERSAMPLE, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_param_check
      $error("uart_rx_param: illegal parameter set");
   end

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] MID_PT    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_PT   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic          ODD_SEL   = (PARITY_ODD != 0);

   uart_rx_state_t       state;
   logic                 rx_sync;
   logic [SW-1:0]        s_cnt;
   logic [BW-1:0]        b_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;
   logic                 stop_bad;
   logic                 mid_pt;
   logic                 full_pt;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_sync)
   );

   assign mid_pt  = s_tick && (s_cnt == MID_PT);
   assign full_pt = s_tick && (s_cnt == FULL_PT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         s_cnt       <= '0;
         b_cnt       <= '0;
         shreg       <= '0;
         par_bad     <= 1'b0;
         stop_bad    <= 1'b0;
         dout        <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         smpl_tick   <= 1'b0;
      end else begin
         smpl_tick   <= 1'b0;
         overrun_err <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  s_cnt <= '0;
                  state <= START;
               end
            end
            // Start bit is checked at mid-bit so later samples land mid-bit too.
            START: begin
               if (mid_pt) begin
                  smpl_tick <= 1'b1;
                  s_cnt     <= '0;
                  if (rx_sync) begin
                     state <= IDLE;
                  end else begin
                     shreg    <= '0;
                     b_cnt    <= '0;
                     par_bad  <= 1'b0;
                     stop_bad <= 1'b0;
                     state    <= DATA;
                  end
               end else if (s_tick) begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            DATA: begin
               if (full_pt) begin
                  smpl_tick <= 1'b1;
                  s_cnt     <= '0;
                  shreg     <= {rx_sync, shreg[DATA_BITS-1:1]};
                  if (b_cnt == LAST_DATA) begin
                     b_cnt <= '0;
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     b_cnt <= b_cnt + 1'b1;
                  end
               end else if (s_tick) begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (full_pt) begin
                  smpl_tick <= 1'b1;
                  s_cnt     <= '0;
                  par_bad   <= parity_bad(9'(shreg), rx_sync, ODD_SEL);
                  state     <= STOP;
               end else if (s_tick) begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            STOP: begin
               if (full_pt) begin
                  smpl_tick <= 1'b1;
                  s_cnt     <= '0;
                  if (!rx_sync) stop_bad <= 1'b1;
                  if (b_cnt == LAST_STOP) begin
                     b_cnt <= '0;
                     state <= DONE;
                  end else begin
                     b_cnt <= b_cnt + 1'b1;
                  end
               end else if (s_tick) begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            // A frame may load in the same cycle the consumer takes the old one.
            DONE: begin
               state <= IDLE;
               if (!rx_valid || rx_ready) begin
                  dout       <= shreg;
                  parity_err <= par_bad;
                  frame_err  <= stop_bad;
                  rx_valid   <= 1'b1;
               end else begin
                  overrun_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
